vector_wb_queue: RTL and testbench

//  Writeback stage directly downstream of the VALU. Buffers VALU results (vd, data, vmask) in a small FIFO.

---
 rtl/vector_wb_queue.sv | 120 ++++++++++++
 tb/tb_vector_wb_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_wb_queue.sv
// Writeback queue between the VALU and the vector register file: buffers results in a small FIFO,
// drains them through a valid/ack write port, and tracks per-register in-flight writes for hazards.
module vector_wb_queue #(
  parameter int unsigned NUM_ELEMENTS = 32,
  parameter int unsigned NUM_VREGS    = 32,
  parameter int unsigned VSEL_W       = $clog2(NUM_VREGS),
  parameter int unsigned DEPTH        = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [VSEL_W-1:0]         issue_vd,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [VSEL_W-1:0]         res_vd,
  input  logic [NUM_ELEMENTS*16-1:0] res_data,
  input  logic [NUM_ELEMENTS-1:0]   res_vmask,
  output logic                      wb_wen,
  output logic [VSEL_W-1:0]         wb_vd,
  output logic [NUM_ELEMENTS*16-1:0] wb_data,
  output logic [NUM_ELEMENTS-1:0]   wb_wmask,
  input  logic                      wb_ack,
  output logic [NUM_VREGS-1:0]      busy,
  output logic [$clog2(DEPTH):0]    count,
  output logic [1:0]                error
);

  localparam int unsigned DW = NUM_ELEMENTS * 16;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [VSEL_W-1:0]       vd_mem_q   [DEPTH];
  logic [DW-1:0]           data_mem_q [DEPTH];
  logic [NUM_ELEMENTS-1:0] mask_mem_q [DEPTH];

  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM_VREGS-1:0] busy_q, busy_d;
  logic [1:0]           error_q, error_d;

  logic                    head_valid;
  logic                    full;
  logic [VSEL_W-1:0]       head_vd;
  logic [DW-1:0]           head_data;
  logic [NUM_ELEMENTS-1:0] head_mask;
  logic                    push;
  logic                    pop;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head_vd    = vd_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];
  assign head_mask  = mask_mem_q[rd_ptr_q];

  // A zero-mask head is retired without a write request; ack is irrelevant for it.
  assign push = res_valid && !full && !flush;
  assign pop  = head_valid && (wb_ack || (head_mask == '0)) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    error_d  = error_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      busy_d   = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue_valid && busy_q[issue_vd] && !(pop && (head_vd == issue_vd))) error_d[0] = 1'b1;
      if (push && !busy_q[res_vd]) error_d[1] = 1'b1;
      // Clear before set so a same-cycle issue to the retiring register stays busy.
      if (pop)         busy_d[head_vd]  = 1'b0;
      if (issue_valid) busy_d[issue_vd] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      error_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  // Payload storage needs no reset: it is only observed through count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      vd_mem_q[wr_ptr_q]   <= res_vd;
      data_mem_q[wr_ptr_q] <= res_data;
      mask_mem_q[wr_ptr_q] <= res_vmask;
    end
  end

  always_comb begin
    res_ready = !nRST && !full;
    wb_wen    = head_valid && (head_mask != '0);
    wb_vd     = head_valid ? head_vd   : '0;
    wb_data   = head_valid ? head_data : '0;
    wb_wmask  = head_valid ? head_mask : '0;
    busy      = busy_q;
    count     = count_q;
    error     = error_q;
  end

endmodule

// File: tb/tb_vector_wb_queue.sv
// Bench for vector_wb_queue: directed scenarios plus random traffic, checked each cycle against a
// queue-based reference model of the writeback stage.
module tb_vector_wb_queue;

  localparam int unsigned NE    = 32;
  localparam int unsigned NV    = 32;
  localparam int unsigned VW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = NE * 16;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic [VW-1:0] issue_vd = '0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [VW-1:0] res_vd = '0;
  logic [DW-1:0] res_data = '0;
  logic [NE-1:0] res_vmask = '0;
  logic          wb_wen;
  logic [VW-1:0] wb_vd;
  logic [DW-1:0] wb_data;
  logic [NE-1:0] wb_wmask;
  logic          wb_ack = 1'b0;
  logic [NV-1:0] busy;
  logic [2:0]    count;
  logic [1:0]    error;

  vector_wb_queue #(
    .NUM_ELEMENTS(NE),
    .NUM_VREGS   (NV),
    .VSEL_W      (VW),
    .DEPTH       (DEPTH)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_vd   (issue_vd),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_vd     (res_vd),
    .res_data   (res_data),
    .res_vmask  (res_vmask),
    .wb_wen     (wb_wen),
    .wb_vd      (wb_vd),
    .wb_data    (wb_data),
    .wb_wmask   (wb_wmask),
    .wb_ack     (wb_ack),
    .busy       (busy),
    .count      (count),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [VW-1:0] vd;
    logic [DW-1:0] data;
    logic [NE-1:0] mask;
  } ent_t;

  ent_t          mq[$];
  logic [NV-1:0] mbusy = '0;
  logic [1:0]    merr = '0;
  int            tests = 0;
  int            fails = 0;

  localparam logic [NE-1:0] ONES = '1;
  localparam logic [DW-1:0] HALF_ONE = {NE{16'h3C00}};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_model();
    bit hv;
    hv = (mq.size() != 0);
    chk("count", DW'(count), DW'(mq.size()));
    chk("res_ready", DW'(res_ready), DW'(mq.size() != DEPTH));
    chk("wb_wen", DW'(wb_wen), DW'(hv && (mq[0].mask != 0)));
    chk("wb_vd", DW'(wb_vd), hv ? DW'(mq[0].vd) : '0);
    chk("wb_data", wb_data, hv ? mq[0].data : '0);
    chk("wb_wmask", DW'(wb_wmask), hv ? DW'(mq[0].mask) : '0);
    chk("busy", DW'(busy), DW'(mbusy));
    chk("error", DW'(error), DW'(merr));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, DW'(res_ready), '0);
    chk({tag, "_wen"}, DW'(wb_wen), '0);
    chk({tag, "_vd"}, DW'(wb_vd), '0);
    chk({tag, "_data"}, wb_data, '0);
    chk({tag, "_mask"}, DW'(wb_wmask), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_count"}, DW'(count), '0);
    chk({tag, "_error"}, DW'(error), '0);
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model, then step past
  // the edge so callers can check post-edge state.
  task automatic cyc(input bit iv, input logic [VW-1:0] ivd, input bit rv,
                     input logic [VW-1:0] rvd, input logic [DW-1:0] d, input logic [NE-1:0] m,
                     input bit ack, input bit fl);
    bit   hv, deq, enq;
    ent_t e;
    @(negedge CLK);
    check_model();
    issue_valid = iv;
    issue_vd    = ivd;
    res_valid   = rv;
    res_vd      = rvd;
    res_data    = d;
    res_vmask   = m;
    wb_ack      = ack;
    flush       = fl;
    if (fl) begin
      mq.delete();
      mbusy = '0;
    end else begin
      hv  = (mq.size() != 0);
      deq = hv && (ack || (mq[0].mask == 0));
      enq = rv && (mq.size() != DEPTH);
      if (iv && mbusy[ivd] && !(deq && (mq[0].vd == ivd))) merr[0] = 1'b1;
      if (enq && !mbusy[rvd]) merr[1] = 1'b1;
      if (deq) begin
        mbusy[mq[0].vd] = 1'b0;
        void'(mq.pop_front());
      end
      if (iv) mbusy[ivd] = 1'b1;
      if (enq) begin
        e.vd = rvd;
        e.data = d;
        e.mask = m;
        mq.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input bit ack);
    cyc(1'b0, '0, 1'b0, '0, '0, '0, ack, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset");
    nRST = 1'b0;

    // 1: single write, ack held high
    cyc(1'b1, 5'd3, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    chk("t1_busy_set", DW'(busy[3]), DW'(1));
    cyc(1'b0, '0, 1'b1, 5'd3, HALF_ONE, ONES, 1'b1, 1'b0);
    chk("t1_count1", DW'(count), DW'(1));
    chk("t1_wen", DW'(wb_wen), DW'(1));
    chk("t1_data", wb_data, HALF_ONE);
    idle(1'b1);
    chk("t1_count0", DW'(count), '0);
    chk("t1_busy_clr", DW'(busy[3]), '0);

    // 2/3: fill to full, then full queue with push and ack together
    for (int i = 0; i < 5; i++) cyc(1'b1, VW'(i), 1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, VW'(i), rnd_data(), ONES, 1'b0, 1'b0);
    chk("t2_full_ready", DW'(res_ready), '0);
    chk("t2_full_count", DW'(count), DW'(4));
    chk("t2_head0", DW'(wb_vd), '0);
    cyc(1'b0, '0, 1'b1, 5'd4, HALF_ONE, ONES, 1'b1, 1'b0);
    chk("t3_pop_only", DW'(count), DW'(3));
    chk("t3_head1", DW'(wb_vd), DW'(1));
    cyc(1'b0, '0, 1'b1, 5'd4, HALF_ONE, ONES, 1'b1, 1'b0);
    chk("t3_push_next", DW'(count), DW'(3));
    chk("t3_head2", DW'(wb_vd), DW'(2));
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t2_drained", DW'(count), '0);

    // 4: zero-mask result
    cyc(1'b1, 5'd7, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 5'd7, rnd_data(), '0, 1'b0, 1'b0);
    chk("t4_wen0", DW'(wb_wen), '0);
    chk("t4_count1", DW'(count), DW'(1));
    idle(1'b0);
    chk("t4_popped", DW'(count), '0);
    chk("t4_busy7", DW'(busy[7]), '0);
    chk("t4_no_err", DW'(error), '0);

    // 5: error flags, sticky through flush
    cyc(1'b1, 5'd2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 5'd2, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("t5_err0", DW'(error), DW'(1));
    cyc(1'b0, '0, 1'b1, 5'd9, rnd_data(), ONES, 1'b1, 1'b0);
    chk("t5_err1", DW'(error), DW'(3));
    idle(1'b1);
    cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("t5_sticky", DW'(error), DW'(3));

    // 6: flush with queued entries and a same-cycle issue, then reset mid-write
    for (int i = 0; i < 3; i++) cyc(1'b1, VW'(10 + i), 1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, VW'(10 + i), rnd_data(), ONES, 1'b0, 1'b0);
    chk("t6_count3", DW'(count), DW'(3));
    cyc(1'b1, 5'd5, 1'b1, 5'd10, rnd_data(), ONES, 1'b0, 1'b1);
    chk("t6_count0", DW'(count), '0);
    chk("t6_busy0", DW'(busy), '0);
    chk("t6_wen0", DW'(wb_wen), '0);
    cyc(1'b1, 5'd6, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 5'd6, rnd_data(), ONES, 1'b0, 1'b0);
    chk("t6_wen1", DW'(wb_wen), DW'(1));
    @(negedge CLK);
    nRST = 1'b1;
    issue_valid = 1'b0;
    res_valid = 1'b0;
    flush = 1'b0;
    #1;
    check_zero("t6_rst");
    mq.delete();
    mbusy = '0;
    merr = '0;
    @(negedge CLK);
    nRST = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [NE-1:0] m;
      m = ($urandom_range(0, 4) == 0) ? '0 : NE'($urandom);
      cyc($urandom_range(0, 9) < 3, VW'($urandom), $urandom_range(0, 1) == 1, VW'($urandom),
          rnd_data(), m, $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end
    @(negedge CLK);
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
